// File: rtl/debouncer_multi.sv
// Multi-channel switch/keypad debouncer: 2-flop synchronizer plus an independent
// stability counter per channel, producing a clean level and registered press/release pulses.
module debouncer_multi #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned COUNT_MAX  = 2400000,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic            any_active
);

  localparam int unsigned       CntW    = $clog2(COUNT_MAX);
  localparam logic [CntW-1:0]   CntLast = CntW'(COUNT_MAX - 1);
  localparam logic [CntW-1:0]   CntOne  = CntW'(1);

  logic [N_CH-1:0] logical_in;
  logic [N_CH-1:0] s1_q, s2_q;
  logic [N_CH-1:0] level_q, level_d;
  logic [N_CH-1:0] rise_q, rise_d;
  logic [N_CH-1:0] fall_q, fall_d;
  logic [CntW-1:0] cnt_q [N_CH];
  logic [CntW-1:0] cnt_d [N_CH];

  // Inversion happens before the synchronizer so reset value 0 always means "inactive".
  assign logical_in = raw_in ^ {N_CH{ACTIVE_LOW}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < int'(N_CH); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q    <= logical_in;
      s2_q    <= s1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int i = 0; i < int'(N_CH); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Per channel: level_q is the stable state, a non-zero count means a candidate change is pending.
  always_comb begin
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntLast) begin
        cnt_d[i]   = '0;
        level_d[i] = s2_q[i];
        rise_d[i]  = s2_q[i];
        fall_d[i]  = ~s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CntOne;
      end
    end
  end

  assign level      = level_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign any_active = |level_q;

endmodule

// File: tb/tb_debouncer_multi.sv
// Bench for debouncer_multi: sliding-window reference model checked every cycle on an
// active-high and an active-low instance, plus directed literal checks of latency and pulses.
module tb_debouncer_multi;

  localparam int unsigned NCh = 4;
  localparam int unsigned Cm  = 8;

  logic           clk   = 1'b0;
  logic           reset = 1'b1;
  logic [NCh-1:0] raw_a = '0;
  logic [NCh-1:0] raw_b = '1;
  logic [NCh-1:0] level_a, rise_a, fall_a;
  logic [NCh-1:0] level_b, rise_b, fall_b;
  logic           any_a, any_b;

  always #5 clk = ~clk;

  debouncer_multi #(.N_CH(NCh), .COUNT_MAX(Cm), .ACTIVE_LOW(1'b0)) u_dut_a (
    .clk        (clk),
    .reset      (reset),
    .raw_in     (raw_a),
    .level      (level_a),
    .rise       (rise_a),
    .fall       (fall_a),
    .any_active (any_a)
  );

  debouncer_multi #(.N_CH(NCh), .COUNT_MAX(Cm), .ACTIVE_LOW(1'b1)) u_dut_b (
    .clk        (clk),
    .reset      (reset),
    .raw_in     (raw_b),
    .level      (level_b),
    .rise       (rise_b),
    .fall       (fall_b),
    .any_active (any_b)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: two-sample delay, then a level flips once the last Cm delayed
  // samples all disagree with it.
  logic [NCh-1:0] m_s1    [2];
  logic [NCh-1:0] m_s2    [2];
  logic [NCh-1:0] m_level [2];
  logic [NCh-1:0] m_rise  [2];
  logic [NCh-1:0] m_fall  [2];
  logic [Cm-1:0]  win     [2][NCh];

  initial begin
    logic [NCh-1:0] lg;
    forever begin
      @(posedge clk or negedge reset);
      for (int d = 0; d < 2; d++) begin
        if (!reset) begin
          m_s1[d] = '0; m_s2[d] = '0; m_level[d] = '0; m_rise[d] = '0; m_fall[d] = '0;
          for (int c = 0; c < int'(NCh); c++) win[d][c] = '0;
        end else begin
          lg = (d == 0) ? raw_a : ~raw_b;
          m_rise[d] = '0;
          m_fall[d] = '0;
          for (int c = 0; c < int'(NCh); c++) begin
            win[d][c] = {win[d][c][Cm-2:0], m_s2[d][c]};
            if (win[d][c] == (m_level[d][c] ? {Cm{1'b0}} : {Cm{1'b1}})) begin
              m_level[d][c] = ~m_level[d][c];
              if (m_level[d][c]) m_rise[d][c] = 1'b1;
              else               m_fall[d][c] = 1'b1;
            end
          end
          m_s2[d] = m_s1[d];
          m_s1[d] = lg;
        end
      end
    end
  end

  bit cmp_en      = 1'b0;
  int rise_a0_cnt = 0;
  int rise_a2_cnt = 0;
  int pulse_b_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rise_a[0]) rise_a0_cnt++;
      if (rise_a[2]) rise_a2_cnt++;
      if ((rise_b | fall_b) != '0) pulse_b_cnt++;
      if (cmp_en) begin
        chk("model_level_a", level_a, m_level[0]);
        chk("model_rise_a",  rise_a,  m_rise[0]);
        chk("model_fall_a",  fall_a,  m_fall[0]);
        chk("model_any_a",   any_a,   |m_level[0]);
        chk("model_level_b", level_b, m_level[1]);
        chk("model_rise_b",  rise_b,  m_rise[1]);
        chk("model_fall_b",  fall_b,  m_fall[1]);
        chk("model_any_b",   any_b,   |m_level[1]);
        chk("rise_fall_excl_a", rise_a & fall_a, 4'b0000);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  int snap;
  int snap_b;

  initial begin
    #1 reset = 1'b0;
    tick(3);
    cmp_en = 1'b1;
    chk("reset_level_a", level_a, 4'b0000);
    chk("reset_any_a",   any_a,   1'b0);
    chk("reset_level_b", level_b, 4'b0000);
    reset = 1'b1;
    snap_b = pulse_b_cnt;

    // Clean press / release on ch0.
    tick(4);
    raw_a[0] = 1'b1;
    tick(9);
    chk("press_e9_level", level_a, 4'b0000);
    tick(1);
    chk("press_e10_level", level_a, 4'b0001);
    chk("press_e10_rise",  rise_a,  4'b0001);
    chk("press_e10_any",   any_a,   1'b1);
    tick(1);
    chk("press_e11_rise", rise_a, 4'b0000);
    tick(3);
    raw_a[0] = 1'b0;
    tick(9);
    chk("release_e9_fall", fall_a, 4'b0000);
    tick(1);
    chk("release_e10_fall",  fall_a,  4'b0001);
    chk("release_e10_level", level_a, 4'b0000);
    tick(1);
    chk("release_e11_fall", fall_a, 4'b0000);

    // Bounce: 3-cycle segments never qualify, the final settle does.
    tick(3);
    snap = rise_a0_cnt;
    for (int k = 0; k < 10; k++) begin
      raw_a[0] = (k % 2 == 0);
      tick(3);
    end
    chk("bounce_no_rise", rise_a0_cnt - snap, 0);
    raw_a[0] = 1'b1;
    tick(9);
    chk("bounce_e9_level", level_a, 4'b0000);
    tick(1);
    chk("bounce_e10_rise", rise_a, 4'b0001);
    chk("bounce_single_rise", rise_a0_cnt - snap, 1);
    raw_a[0] = 1'b0;
    tick(14);

    // Threshold on ch2: 7 cycles rejected, 8 cycles accepted.
    snap = rise_a2_cnt;
    raw_a[2] = 1'b1;
    tick(7);
    raw_a[2] = 1'b0;
    tick(20);
    chk("glitch7_level", level_a, 4'b0000);
    chk("glitch7_no_rise", rise_a2_cnt - snap, 0);
    raw_a[2] = 1'b1;
    tick(8);
    raw_a[2] = 1'b0;
    tick(2);
    chk("pulse8_rise",  rise_a,  4'b0100);
    chk("pulse8_level", level_a, 4'b0100);
    tick(7);
    chk("pulse8_fall_early", fall_a, 4'b0000);
    tick(1);
    chk("pulse8_fall", fall_a, 4'b0100);
    chk("pulse8_one_rise", rise_a2_cnt - snap, 1);
    tick(4);

    // Independence and any_active.
    raw_a[1] = 1'b1;
    raw_a[2] = 1'b1;
    tick(4);
    raw_a[3] = 1'b1;
    tick(5);
    chk("indep_e9_level", level_a, 4'b0000);
    tick(1);
    chk("indep_e10_rise",  rise_a,  4'b0110);
    chk("indep_e10_level", level_a, 4'b0110);
    tick(4);
    chk("indep_e14_rise",  rise_a,  4'b1000);
    chk("indep_e14_level", level_a, 4'b1110);
    raw_a[1] = 1'b0;
    tick(10);
    chk("indep_fall1", fall_a, 4'b0010);
    chk("indep_any1",  any_a,  1'b1);
    raw_a[2] = 1'b0;
    raw_a[3] = 1'b0;
    tick(9);
    chk("indep_any_held", any_a, 1'b1);
    tick(1);
    chk("indep_fall23", fall_a, 4'b1100);
    chk("indep_any_clear", any_a, 1'b0);
    tick(3);

    // Reset mid-operation: ch0 qualified, ch3 pending.
    raw_a[0] = 1'b1;
    tick(16);
    raw_a[3] = 1'b1;
    tick(4);
    chk("prereset_level", level_a, 4'b0001);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_level", level_a, 4'b0000);
    chk("async_reset_any",   any_a,   1'b0);
    chk("async_reset_rise",  rise_a | fall_a, 4'b0000);
    tick(3);
    reset = 1'b1;
    tick(9);
    chk("post_reset_e9_level", level_a, 4'b0000);
    tick(1);
    chk("post_reset_e10_rise",  rise_a,  4'b1001);
    chk("post_reset_e10_level", level_a, 4'b1001);
    raw_a = '0;
    tick(12);

    // Active-low instance: idle-high lines never pulsed, then a press on ch0.
    chk("al_idle_level", level_b, 4'b0000);
    chk("al_idle_no_pulse", pulse_b_cnt - snap_b, 0);
    raw_b[0] = 1'b0;
    tick(9);
    chk("al_e9_level", level_b, 4'b0000);
    tick(1);
    chk("al_e10_level", level_b, 4'b0001);
    chk("al_e10_rise",  rise_b,  4'b0001);
    chk("al_e10_any",   any_b,   1'b1);
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
